// File: rtl/breakout_audio_pkg.sv
// ---------------------------------------------------------------------------
// breakout_audio_pkg
// Definitions shared by the audio event block and tone_player.
//   - Sound codes carried on the 4-bit sound_code bus.
//   - State encoding of the tone_player fetch/play sequencer.
// ---------------------------------------------------------------------------
package breakout_audio_pkg;

    // Sound codes
    localparam logic [3:0] SND_NONE   = 4'd0;
    localparam logic [3:0] SND_WALL   = 4'd1;
    localparam logic [3:0] SND_PLATE  = 4'd2;
    localparam logic [3:0] SND_GROUND = 4'd3;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_PLAY = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        ACK  = ST_ACK,
        PLAY = ST_PLAY
    } state_e;

endpackage : breakout_audio_pkg

// File: rtl/tone_div.sv
// ---------------------------------------------------------------------------
// tone_div
// Half-period counter plus the square-wave tone bit.
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   load_i       in   start a tone: counter <= hp_m1_i, tone bit <= 1
//   en_i         in   advance one cycle: count down, toggle and reload at 0
//   clr_i        in   stop the tone: counter and tone bit cleared (wins)
//   hp_m1_i      in   half-period minus one, reload value
//   tone_next_o  out  value the tone bit takes on the next rising edge
// The next-state value is exported so the owner can register a gated copy
// (speaker) that changes on the same edge as the tone bit itself.
// ---------------------------------------------------------------------------
module tone_div #(
    parameter int unsigned HP_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [HP_W-1:0] hp_m1_i,
    output logic            tone_next_o
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (clr_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (load_i) begin
            cnt_d  = hp_m1_i;
            tone_d = 1'b1;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_d  = hp_m1_i;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_next_o = tone_d;

endmodule : tone_div

// File: rtl/tone_player.sv
// ---------------------------------------------------------------------------
// tone_player
// Fetches 4-bit sound codes with a four-phase Data_request/Data_ready
// handshake and plays each non-zero code as a fixed-length square wave.
//   clk           in   system clock (rising edge)
//   reset         in   asynchronous active-low reset
//   Data_ready    in   upstream presents a valid sound_code
//   sound_code    in   code, sampled in REQ when Data_ready is 1
//   mute          in   forces speaker low; timing unaffected
//   Data_request  out  waiting for a code
//   speaker       out  registered square-wave output
//   busy          out  tone is playing
// Half-period is DIV_UNIT*(16-code) cycles; a tone lasts DUR_CYCLES cycles.
// ---------------------------------------------------------------------------
module tone_player
    import breakout_audio_pkg::*;
#(
    parameter int unsigned DIV_UNIT   = 3125,
    parameter int unsigned DUR_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Data_ready,
    input  logic [3:0] sound_code,
    input  logic       mute,
    output logic       Data_request,
    output logic       speaker,
    output logic       busy
);

    localparam int unsigned HP_W  = $clog2(15 * DIV_UNIT + 1);
    localparam int unsigned DUR_W = $clog2(DUR_CYCLES + 1);

    state_e           state_q;
    logic [3:0]       code_q;
    logic [DUR_W-1:0] dur_q;
    logic             dreq_q;
    logic             busy_q;
    logic             speaker_q;

    // Half-period at full width; code 0 never reaches PLAY so its
    // out-of-range value is harmless.
    logic [31:0]     hp_full;
    logic [HP_W-1:0] hp_m1;
    assign hp_full = DIV_UNIT * (32'd16 - 32'(code_q));
    assign hp_m1   = HP_W'(hp_full - 32'd1);

    // Tone divider control, decoded from the sequencer state.
    logic tone_load, tone_en, tone_clr, tone_next;
    assign tone_load = (state_q == ACK) && !Data_ready && (code_q != SND_NONE);
    // End of duration clears the tone bit and suppresses a coincident toggle.
    assign tone_en   = (state_q == PLAY) && (dur_q != '0);
    assign tone_clr  = (state_q == PLAY) && (dur_q == '0);

    tone_div #(
        .HP_W (HP_W)
    ) u_tone_div (
        .clk         (clk),
        .reset       (reset),
        .load_i      (tone_load),
        .en_i        (tone_en),
        .clr_i       (tone_clr),
        .hp_m1_i     (hp_m1),
        .tone_next_o (tone_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            code_q    <= SND_NONE;
            dur_q     <= '0;
            dreq_q    <= 1'b0;
            busy_q    <= 1'b0;
            speaker_q <= 1'b0;
        end else begin
            // Gated copy of the tone bit, updated on the same edge.
            speaker_q <= tone_next & ~mute;
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    dreq_q  <= 1'b1;
                end
                REQ: begin
                    if (Data_ready) begin
                        code_q  <= sound_code;
                        dreq_q  <= 1'b0;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!Data_ready) begin
                        if (code_q == SND_NONE) begin
                            state_q <= REQ;
                            dreq_q  <= 1'b1;
                        end else begin
                            dur_q   <= DUR_W'(DUR_CYCLES - 1);
                            busy_q  <= 1'b1;
                            state_q <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (dur_q == '0) begin
                        busy_q  <= 1'b0;
                        dreq_q  <= 1'b1;
                        state_q <= REQ;
                    end else begin
                        dur_q <= dur_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Data_request = dreq_q;
    assign busy         = busy_q;
    assign speaker      = speaker_q;

endmodule : tone_player
